auth_verifier: RTL and testbench
================================

# auth_verifier

Challenge-response verifier for the hardware authentication path. It captures a 16-bit challenge from the on-chip `lfsr` generator and issues it to the device under authentication. It then waits a bounded time for a 16-bit response, compares that response against a keyed transform of the challenge, and reports pass or fail. Consecutive failures are counted, and after too many the block enforces a timed lockout.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: cycles spent in WAIT before an absent response counts as a fail (≥2).
- `MAX_FAILS`, 3: consecutive fails that trigger lockout (1..7).
- `LOCK_CYCLES`, 1023: lockout duration in cycles (≥1).
- `KEY`, 16'hA5C3: secret key used by the response transform.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `challenge_in`  in  16  challenge source, driven by `lfsr.d_out`.
- `start`  in  1  request a new authentication; sampled only in IDLE.
- `chal_valid`  out  1  one-cycle strobe; `chal_out` is valid in that cycle.
- `chal_out`  out  16  captured challenge, held stable until the next capture.
- `resp_valid`  in  1  response strobe; honoured only in WAIT.
- `resp_data`  in  16  response word, sampled together with `resp_valid`.
- `done`  out  1  one-cycle pulse when a verdict is produced.
- `pass`  out  1  verdict of the last attempt, held until the next `done`.
- `busy`  out  1  high in every state except IDLE.
- `locked`  out  1  high while in LOCK.
- `fail_count`  out  3  current consecutive-fail count.

## Operation
- Expected response: `x = c ^ KEY`, then `exp = {x[12:0], x[15:13]} ^ {c[7:0], c[15:8]}`, where `c` is the captured challenge.
- The FSM has five states: IDLE, ISSUE, WAIT, CHECK, LOCK.
- IDLE:
  - `start=1` captures `challenge_in` into the challenge register and moves to ISSUE.
  - Otherwise the FSM stays in IDLE.
- ISSUE:
  - `chal_valid=1`, the timer is cleared, and the FSM moves to WAIT.
- WAIT:
  - The timer increments every cycle.
  - `resp_valid=1` captures `resp_data` and moves to CHECK.
  - If the timer reaches `TIMEOUT_CYCLES-1` with no response, the timeout flag is set and the FSM moves to CHECK.
  - If `resp_valid` and timeout occur in the same cycle, the response wins and the timeout flag stays clear.
- CHECK:
  - `done=1` for this cycle.
  - `pass` is set to `(resp == exp) & !timeout`.
  - On a pass, `fail_count` is cleared and the FSM returns to IDLE.
  - On a fail, `fail_count` increments. If the new count equals `MAX_FAILS` the FSM moves to LOCK; otherwise it returns to IDLE.
- LOCK:
  - `locked=1` and the lock timer counts `LOCK_CYCLES` cycles.
  - When the count expires, `fail_count` is cleared and the FSM moves to IDLE.
  - `start` is ignored throughout.
- `resp_valid` outside WAIT is ignored and has no side effects. `start` outside IDLE is ignored and is not queued.
- Reset may be asserted in any state, mid-operation included. It forces IDLE immediately, clears all counters and registers, and discards any pending attempt.

## Timing
- Reset values: `chal_valid=0`, `chal_out=16'h0000`, `done=0`, `pass=0`, `busy=0`, `locked=0`, `fail_count=0`. FSM is in IDLE and both timers are 0.
- `start` is sampled at edge t0:
  - `chal_valid` is high during cycle t0+1.
  - WAIT begins at cycle t0+2.
- A `resp_valid` sampled at edge t produces `done` during cycle t+1. Verdict latency is 1 cycle.
- With no response, WAIT lasts exactly `TIMEOUT_CYCLES` cycles, so `done` falls in cycle t0+2+`TIMEOUT_CYCLES`.
- The earliest accepted response is in cycle t0+2, the first WAIT cycle. A response during the `chal_valid` cycle is ignored.
- After CHECK, IDLE is re-entered on the next cycle, so back-to-back attempts are spaced at least 4 cycles apart.
- LOCK occupies exactly `LOCK_CYCLES` cycles; `locked` falls on the first IDLE cycle.
- All outputs are registered.

## Structure
- Shared package `auth_pkg` holds:
  - the state enum (IDLE, ISSUE, WAIT, CHECK, LOCK);
  - the default `KEY` constant;
  - a function computing `exp` from `c` and the key.
- Sub-module `auth_resp_calc` is the purely combinational transform wrapping the package function; it is reused by the device-side responder.
- `lfsr` is instantiated at the integration level, not inside this block.

## Test plan
- Reset, then `challenge_in=16'h2359` (the LFSR seed), pulse `start`, respond with `16'h6DF7` two cycles after `chal_valid` -> `chal_out=16'h2359`; `done` one cycle after the response with `pass=1`; `fail_count=0`.
- Same challenge, respond with `16'h6DF6` -> `done`, `pass=0`, `fail_count=1`, FSM back in IDLE (`busy=0`).
- No response after `chal_valid` -> `done` exactly 255 cycles after WAIT entry with `pass=0`; `fail_count` increments.
- Three consecutive fails -> `locked=1` the cycle after the third `done`; `start` during LOCK produces no `chal_valid`; `locked=0` and `fail_count=0` after 1023 cycles.
- Correct response landing on the last WAIT cycle (timer = 254) -> `pass=1`. A `resp_valid` pulse while IDLE -> no `done` and no state change.
- Assert `reset` mid-WAIT, then release -> all outputs at reset values; a later response without a new `start` produces no `done`.

Source files
------------

// File: rtl/auth_pkg.sv
// Shared types and the keyed response transform for the challenge-response verifier.
package auth_pkg;

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StCheck, StLock} auth_state_e;

    localparam logic [15:0] DEFAULT_KEY = 16'hA5C3;

    // Response a genuine device must return for challenge `chal`.
    function automatic logic [15:0] auth_expected(input logic [15:0] chal,
                                                  input logic [15:0] key);
        logic [15:0] x;
        x = chal ^ key;
        return {x[12:0], x[15:13]} ^ {chal[7:0], chal[15:8]};
    endfunction

endpackage

// File: rtl/auth_verifier_if.sv
// Challenge/response handshake between the verifier and the integration level.
interface auth_verifier_if;

    logic [15:0] challenge_in;
    logic        start;
    logic        chal_valid;
    logic [15:0] chal_out;
    logic        resp_valid;
    logic [15:0] resp_data;
    logic        done;
    logic        pass;
    logic        busy;
    logic        locked;
    logic [2:0]  fail_count;

    modport master (
        output challenge_in, start, resp_valid, resp_data,
        input  chal_valid, chal_out, done, pass, busy, locked, fail_count
    );

    modport slave (
        input  challenge_in, start, resp_valid, resp_data,
        output chal_valid, chal_out, done, pass, busy, locked, fail_count
    );

endinterface

// File: rtl/auth_resp_calc.sv
// Combinational keyed transform; shared with the device-side responder.
module auth_resp_calc
    import auth_pkg::*;
#(
    parameter logic [15:0] KEY = DEFAULT_KEY
) (
    input  logic [15:0] chal,
    output logic [15:0] expected
);

    assign expected = auth_expected(chal, KEY);

endmodule

// File: rtl/auth_verifier.sv
// Issues a captured challenge, checks the response within a time window, and
// enforces a timed lockout after repeated consecutive failures.
module auth_verifier
    import auth_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned LOCK_CYCLES    = 1023,
    parameter logic [15:0] KEY            = DEFAULT_KEY
) (
    input  logic           clk,
    input  logic           reset,
    auth_verifier_if.slave bus
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    auth_state_e   state_q, state_d;
    logic [TW-1:0] wait_q, wait_d;
    logic [LW-1:0] lock_q, lock_d;
    logic [15:0]   chal_q, chal_d;
    logic          pass_q, pass_d;
    logic [2:0]    fail_q, fail_d;
    logic          chal_valid_q, done_q, busy_q, locked_q;
    logic          verdict;
    logic [15:0]   expected;

    auth_resp_calc #(
        .KEY(KEY)
    ) u_resp_calc (
        .chal    (chal_q),
        .expected(expected)
    );

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        lock_d  = lock_q;
        chal_d  = chal_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        verdict = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    chal_d  = bus.challenge_in;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                wait_d  = '0;
                state_d = StWait;
            end
            StWait: begin
                wait_d = wait_q + TW'(1);
                // A response in the final window cycle beats the timeout.
                if (bus.resp_valid) begin
                    pass_d  = (bus.resp_data == expected);
                    verdict = 1'b1;
                end else if (wait_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    pass_d  = 1'b0;
                    verdict = 1'b1;
                end
                if (verdict) begin
                    fail_d  = pass_d ? 3'd0 : fail_q + 3'd1;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                lock_d  = '0;
                state_d = (fail_q == 3'(MAX_FAILS)) ? StLock : StIdle;
            end
            StLock: begin
                lock_d = lock_q + LW'(1);
                if (lock_q == LW'(LOCK_CYCLES - 1)) begin
                    fail_d  = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            wait_q       <= '0;
            lock_q       <= '0;
            chal_q       <= '0;
            pass_q       <= 1'b0;
            fail_q       <= '0;
            chal_valid_q <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            lock_q       <= lock_d;
            chal_q       <= chal_d;
            pass_q       <= pass_d;
            fail_q       <= fail_d;
            chal_valid_q <= (state_d == StIssue);
            done_q       <= (state_d == StCheck);
            busy_q       <= (state_d != StIdle);
            locked_q     <= (state_d == StLock);
        end
    end

    assign bus.chal_valid = chal_valid_q;
    assign bus.chal_out   = chal_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.busy       = busy_q;
    assign bus.locked     = locked_q;
    assign bus.fail_count = fail_q;

endmodule

// File: tb/tb_auth_verifier.sv
// Directed bench: per-cycle expected-output timeline built from attempt-level rules.
module tb_auth_verifier;

    localparam int          TIMEOUT = 255;
    localparam int          MAXF    = 3;
    localparam int          LOCK    = 1023;
    localparam logic [15:0] KEY     = 16'hA5C3;
    localparam int          MAXC    = 4096;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    auth_verifier_if bus ();

    auth_verifier #(
        .TIMEOUT_CYCLES(TIMEOUT),
        .MAX_FAILS     (MAXF),
        .LOCK_CYCLES   (LOCK),
        .KEY           (KEY)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs, indexed by cycle number.
    logic [15:0] e_chal [MAXC];
    bit          e_cv   [MAXC];
    bit          e_done [MAXC];
    bit          e_pass [MAXC];
    bit          e_busy [MAXC];
    bit          e_lock [MAXC];
    logic [2:0]  e_fail [MAXC];

    int n_checks = 0;
    int n_errors = 0;
    int m_fail = 0;
    int last_start = 0;
    int last_done = -1;
    int done_cnt = 0;
    int lock_cnt = 0;
    int cv_cnt = 0;

    function automatic logic [15:0] model_exp(input logic [15:0] c);
        int unsigned cu, x, rot, sw;
        cu  = c;
        x   = cu ^ KEY;
        rot = ((x << 3) | (x >> 13)) & 32'hFFFF;
        sw  = ((cu << 8) | (cu >> 8)) & 32'hFFFF;
        return 16'(rot ^ sw);
    endfunction

    function automatic void clear_from(input int k);
        for (int i = k; i < MAXC; i++) begin
            e_chal[i] = 16'h0000;
            e_cv[i]   = 1'b0;
            e_done[i] = 1'b0;
            e_pass[i] = 1'b0;
            e_busy[i] = 1'b0;
            e_lock[i] = 1'b0;
            e_fail[i] = 3'd0;
        end
    endfunction

    // Start presented in cycle n; response presented in cycle rc (or -1 for none).
    function automatic void plan_attempt(input int n, input logic [15:0] c, input int rc,
                                         input logic [15:0] r, output int dc, output int nxt);
        bit ok;
        e_cv[n+1] = 1'b1;
        for (int i = n + 1; i < MAXC; i++) e_chal[i] = c;
        dc = (rc >= 0) ? rc + 1 : n + 2 + TIMEOUT;
        ok = (rc >= 0) && (r == model_exp(c));
        for (int i = n + 1; i <= dc; i++) e_busy[i] = 1'b1;
        e_done[dc] = 1'b1;
        for (int i = dc; i < MAXC; i++) e_pass[i] = ok;
        m_fail = ok ? 0 : m_fail + 1;
        for (int i = dc; i < MAXC; i++) e_fail[i] = 3'(m_fail);
        nxt = dc + 1;
        if (m_fail == MAXF) begin
            for (int i = dc + 1; i <= dc + LOCK; i++) begin
                e_busy[i] = 1'b1;
                e_lock[i] = 1'b1;
            end
            nxt = dc + 1 + LOCK;
            for (int i = nxt; i < MAXC; i++) e_fail[i] = 3'd0;
            m_fail = 0;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (cyc >= MAXC) begin
            n_checks++;
            n_errors++;
            $display("FAIL cycle_budget: got cycle %0d, want below %0d", cyc, MAXC);
        end else begin
            n_checks++;
            if (bus.chal_valid !== e_cv[cyc] || bus.done !== e_done[cyc] ||
                bus.pass !== e_pass[cyc] || bus.busy !== e_busy[cyc] ||
                bus.locked !== e_lock[cyc] || bus.fail_count !== e_fail[cyc] ||
                bus.chal_out !== e_chal[cyc]) begin
                n_errors++;
                $display("FAIL cycle_%0d outputs: got cv=%b done=%b pass=%b busy=%b lock=%b fail=%0d chal=%h, want cv=%b done=%b pass=%b busy=%b lock=%b fail=%0d chal=%h",
                         cyc, bus.chal_valid, bus.done, bus.pass, bus.busy, bus.locked,
                         bus.fail_count, bus.chal_out, e_cv[cyc], e_done[cyc], e_pass[cyc],
                         e_busy[cyc], e_lock[cyc], e_fail[cyc], e_chal[cyc]);
            end
        end
        if (bus.done === 1'b1) begin
            done_cnt++;
            last_done = cyc;
        end
        if (bus.locked === 1'b1) lock_cnt++;
        if (bus.chal_valid === 1'b1) cv_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // noise: hold start high while busy and pulse resp_valid outside the wait window.
    task automatic run_attempt(input logic [15:0] c, input int rdelay, input logic [15:0] r,
                               input bit noise);
        int n, rc, dc, nxt;
        bit in_wait;
        n  = cyc;
        rc = (rdelay < 0) ? -1 : n + 2 + rdelay;
        plan_attempt(n, c, rc, r, dc, nxt);
        last_start = n;
        bus.challenge_in = c;
        bus.start = 1'b1;
        bus.resp_valid = 1'b0;
        step();
        while (cyc < nxt) begin
            bus.challenge_in = 16'($urandom);
            bus.start = noise;
            in_wait = (cyc >= n + 2) && (cyc < dc);
            bus.resp_valid = (cyc == rc) || (noise && !in_wait);
            bus.resp_data = (cyc == rc) ? r : model_exp(c);
            step();
        end
        bus.start = 1'b0;
        bus.resp_valid = 1'b0;
    endtask

    initial begin
        #(MAXC * 10);
        $display("FAIL watchdog: got no finish, want finish within %0d cycles", MAXC);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, d0, l0, c0;
        bus.challenge_in = 16'h0000;
        bus.start = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_data = 16'h0000;
        clear_from(0);
        #1 reset = 1'b0;
        step();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_chal_out", 32'(bus.chal_out), 32'h0);
        check("rst_fail_count", 32'(bus.fail_count), 32'd0);
        check("rst_pass_locked", 32'({bus.pass, bus.locked, bus.done, bus.chal_valid}), 32'd0);
        step();
        step();
        reset = 1'b1;
        step();
        step();

        check("model_pin_2359", 32'(model_exp(16'h2359)), 32'h6DF7);

        run_attempt(16'h2359, 1, 16'h6DF7, 1'b0);
        check("a1_pass", 32'(bus.pass), 32'd1);
        check("a1_chal_out", 32'(bus.chal_out), 32'h2359);
        check("a1_fail_count", 32'(bus.fail_count), 32'd0);
        check("a1_latency", 32'(last_done - last_start), 32'd4);

        run_attempt(16'h2359, 1, 16'h6DF6, 1'b0);
        check("a2_pass", 32'(bus.pass), 32'd0);
        check("a2_fail_count", 32'(bus.fail_count), 32'd1);
        check("a2_busy", 32'(bus.busy), 32'd0);

        run_attempt(16'h7C01, -1, 16'h0000, 1'b1);
        check("a3_timeout_latency", 32'(last_done - last_start), 32'd257);
        check("a3_fail_count", 32'(bus.fail_count), 32'd2);

        l0 = lock_cnt;
        c0 = cv_cnt;
        run_attempt(16'h1234, 3, 16'hDEAD, 1'b1);
        check("a4_lock_cycles", 32'(lock_cnt - l0), 32'd1023);
        check("a4_no_cv_in_lock", 32'(cv_cnt - c0), 32'd1);
        check("a4_fail_cleared", 32'(bus.fail_count), 32'd0);
        check("a4_unlocked", 32'(bus.locked), 32'd0);

        d0 = done_cnt;
        bus.resp_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.resp_data = 16'($urandom);
            step();
        end
        bus.resp_valid = 1'b0;
        step();
        check("idle_resp_no_done", 32'(done_cnt - d0), 32'd0);

        run_attempt(16'hBEEF, TIMEOUT - 1, model_exp(16'hBEEF), 1'b0);
        check("a5_last_cycle_pass", 32'(bus.pass), 32'd1);
        check("a5_latency", 32'(last_done - last_start), 32'd257);

        run_attempt(16'h0001, 0, 16'h0000, 1'b0);
        check("a6_fail_count", 32'(bus.fail_count), 32'd1);

        n = cyc;
        bus.challenge_in = 16'h5A5A;
        bus.start = 1'b1;
        e_cv[n+1] = 1'b1;
        for (int i = n + 1; i < MAXC; i++) e_chal[i] = 16'h5A5A;
        for (int i = n + 1; i < n + 10; i++) e_busy[i] = 1'b1;
        step();
        bus.start = 1'b0;
        while (cyc < n + 10) step();
        clear_from(n + 10);
        m_fail = 0;
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        d0 = done_cnt;
        step();
        step();
        bus.resp_valid = 1'b1;
        bus.resp_data = model_exp(16'h5A5A);
        step();
        bus.resp_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
        check("rst_mid_chal_out", 32'(bus.chal_out), 32'h0);
        check("rst_mid_fail_count", 32'(bus.fail_count), 32'd0);
        check("rst_mid_busy", 32'(bus.busy), 32'd0);

        run_attempt(16'hFFFF, 0, model_exp(16'hFFFF), 1'b0);
        check("a7_pass", 32'(bus.pass), 32'd1);
        check("a7_chal_out", 32'(bus.chal_out), 32'hFFFF);
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
